// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
//
// Serial-in/parallel-out receiver for a framed bit stream:
//   start bit (0), WIDTH data bits (MSB- or LSB-first), [parity], stop bit (1).
// A correctly framed word is presented on p_out with a one-cycle p_valid
// strobe. A bad stop bit (or a bad parity bit) gives a one-cycle frame_err
// strobe instead, and p_out keeps its previous value.
//
// Optional feature macro: RX_PARITY_CHECK_EN
//   defined   : a parity bit follows the data bits. The data bits plus the
//               parity bit must have even parity.
//   undefined : there is no parity bit (frame = WIDTH+2 bits).
//
// Parameters:
//   WIDTH      data bits per frame (2..16)
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous reset, active-low
//   s_in       in   serial line, idles high
//   s_valid    in   bit strobe; s_in is sampled only when s_valid=1
//   lsb_first  in   0 = MSB-first, 1 = LSB-first; latched at the start bit
//   p_out      out  last correctly framed word
//   p_valid    out  one-cycle pulse, p_out updated this cycle
//   frame_err  out  one-cycle pulse, bad stop bit or bad parity
//   busy       out  high while a frame is in progress
// -----------------------------------------------------------------------------
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef RX_PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             p_valid_q, p_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             par_err_s;

`ifdef RX_PARITY_CHECK_EN
  logic par_err_q, par_err_d;

  // Even parity over data plus parity bit: any XOR of 1 is a mismatch.
  function automatic logic parity_mismatch(input logic [WIDTH-1:0] data,
                                           input logic             par);
    parity_mismatch = (^data) ^ par;
  endfunction

  assign par_err_s = par_err_q;
`else
  assign par_err_s = 1'b0;
`endif

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      p_out_q     <= '0;
      p_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      p_out_q     <= p_out_d;
      p_valid_q   <= p_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef RX_PARITY_CHECK_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Next-state and datapath logic; everything holds unless a bit is accepted,
  // except the strobes which default low every cycle.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    p_out_d     = p_out_q;
    p_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;
`ifdef RX_PARITY_CHECK_EN
    par_err_d   = par_err_q;
`endif

    if (s_valid) begin
      case (state_q)
        IDLE: begin
          if (!s_in) begin
            state_d = DATA;
            busy_d  = 1'b1;
            cnt_d   = '0;
            dir_d   = lsb_first;
`ifdef RX_PARITY_CHECK_EN
            par_err_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end

        DATA: begin
          if (dir_q) begin
            shreg_d = {s_in, shreg_q[WIDTH-1:1]};
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], s_in};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
`ifdef RX_PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = DATA;
          end
        end

`ifdef RX_PARITY_CHECK_EN
        PARITY: begin
          par_err_d = parity_mismatch(shreg_q, s_in);
          state_d   = STOP;
        end
`endif

        STOP: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          // A parity failure still consumes the stop bit, then reports error.
          if (s_in && !par_err_s) begin
            p_out_d   = shreg_q;
            p_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign p_out     = p_out_q;
  assign p_valid   = p_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
